fifo_sync_pro: RTL

FIFO_SYNC_PRO -- requirements
Module: fifo_sync_pro

---
 rtl/fifo_sync_pro.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_sync_pro.sv
// Synchronous FIFO with count, almost/full/empty status, sticky error flags and flush.
// Show-ahead q (OUT_REG=0) or 1-cycle registered q (OUT_REG=1); writes refused at full, reads refused at empty.
module fifo_sync_pro #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit OUT_REG    = 1'b0,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rd_req,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   fifo_num,
    output logic                  rd_empty,
    output logic                  wr_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 2**ADDR_WIDTH;
    localparam logic [31:0]       DEPTH_W = DEPTH;
    localparam logic [31:0]       AF_W    = AF_LEVEL;
    localparam logic [31:0]       AE_W    = AE_LEVEL;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH_W[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_W[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_W[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr_next;
    logic [ADDR_WIDTH-1:0] rd_addr_next;
    logic [ADDR_WIDTH:0]   num_next;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ovf_set;
    logic                  unf_set;

    // Flush takes priority over both requests; flags come from the registered count.
    assign wr_en = wr_req & ~wr_full  & ~flush;
    assign rd_en = rd_req & ~rd_empty & ~flush;

    // A write colliding with an accepted pop at full is a planned drop, not an overflow.
    assign ovf_set = wr_req & wr_full  & ~rd_en & ~flush;
    assign unf_set = rd_req & rd_empty & ~flush;

    always_comb begin
        wr_addr_next = wr_addr;
        rd_addr_next = rd_addr;
        num_next     = fifo_num;
        if (flush) begin
            wr_addr_next = '0;
            rd_addr_next = '0;
            num_next     = '0;
        end else begin
            if (wr_en) begin
                wr_addr_next = wr_addr + 1'b1;
            end
            if (rd_en) begin
                rd_addr_next = rd_addr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                num_next = fifo_num + CNT_ONE;
            end else if (rd_en && !wr_en) begin
                num_next = fifo_num - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            fifo_num     <= '0;
            rd_empty     <= 1'b1;
            wr_full      <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            wr_addr      <= wr_addr_next;
            rd_addr      <= rd_addr_next;
            fifo_num     <= num_next;
            rd_empty     <= (num_next == '0);
            wr_full      <= (num_next == DEPTH_C);
            almost_empty <= (num_next <= AE_C);
            almost_full  <= (num_next >= AF_C);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q_r;
            logic                  rd_valid_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r        <= '0;
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_en;
                    if (rd_en) begin
                        q_r <= mem[rd_addr];
                    end
                end
            end

            assign q        = q_r;
            assign rd_valid = rd_valid_r;
        end else begin : g_out_comb
            assign q        = mem[rd_addr];
            assign rd_valid = rd_en;
        end
    endgenerate

endmodule
